// File: rtl/btb_pkg.sv
// btb_pkg: shared helpers for the branch target buffer.
//   btb_clog2    - ceiling log2 used to size the index field
//   btb_idx_w    - index width for a given table depth
//   btb_tag_w    - tag width left after the word offset and index bits
//   btb_cnt_*    - saturating direction counter constants (max, weakly
//                  taken, weakly not taken) for a given counter width
package btb_pkg;

  function automatic int btb_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int btb_idx_w(input int entries);
    return btb_clog2(entries);
  endfunction

  // Two low PC bits are the byte offset within a word and carry no information.
  function automatic int btb_tag_w(input int addr_w, input int entries);
    return addr_w - 2 - btb_idx_w(entries);
  endfunction

  function automatic int btb_cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

  function automatic int btb_cnt_weak_t(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  function automatic int btb_cnt_weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// btb_sat_counter: next value of a CNT_W-bit saturating up/down counter.
//   cnt_i  - current counter value
//   inc_i  - 1: count up (saturate at max), 0: count down (saturate at 0)
//   cnt_o  - next counter value
module btb_sat_counter
  import btb_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(btb_cnt_max(CNT_W));

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_W'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predict_btb.sv
// branch_predict_btb: direct-mapped branch target buffer for the IF stage.
//   CLK, RESET          - clock, synchronous active-high reset
//   IF_PC               - fetch PC; IF_Hit / IF_Predict_Taken / IF_Next_PC
//                         are combinational functions of it and the table
//   Update_*            - resolved branch from ID, written at the clock edge
//   Flush_All           - clears every valid bit at the next edge
//   Stat_Updates        - count of Update_Valid cycles (wraps)
//   Stat_Mispredicts    - count of updates with Taken != Predicted (wraps)
module branch_predict_btb
  import btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] IF_PC,
  output logic              IF_Hit,
  output logic              IF_Predict_Taken,
  output logic [ADDR_W-1:0] IF_Next_PC,
  input  logic              Update_Valid,
  input  logic [ADDR_W-1:0] Update_PC,
  input  logic              Update_Taken,
  input  logic              Update_Predicted,
  input  logic [ADDR_W-1:0] Update_Target,
  input  logic              Flush_All,
  output logic [STAT_W-1:0] Stat_Updates,
  output logic [STAT_W-1:0] Stat_Mispredicts
);

  localparam int IDX_W = btb_idx_w(ENTRIES);
  localparam int TAG_W = btb_tag_w(ADDR_W, ENTRIES);

  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(btb_cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(btb_cnt_weak_nt(CNT_W));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] target;
    logic [CNT_W-1:0]  cnt;
  } btb_entry_t;

  localparam btb_entry_t RESET_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    cnt:    CNT_WEAK_NT
  };

  btb_entry_t table_q [ENTRIES];
  btb_entry_t table_d [ENTRIES];

  logic [STAT_W-1:0] stat_upd_q, stat_upd_d;
  logic [STAT_W-1:0] stat_mis_q, stat_mis_d;

  // Byte-offset bits never take part in indexing or tag compare.
  logic [3:0] unused_pc_bits;
  assign unused_pc_bits = {IF_PC[1:0], Update_PC[1:0]};

  // ---------------- Lookup ----------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;

  assign if_idx = IF_PC[IDX_W+1:2];
  assign if_tag = IF_PC[ADDR_W-1:IDX_W+2];

  // Reads table_q only: an update to the same index this cycle is not
  // visible until the following cycle.
  assign IF_Hit           = table_q[if_idx].valid && (table_q[if_idx].tag == if_tag);
  assign IF_Predict_Taken = IF_Hit && table_q[if_idx].cnt[CNT_W-1];
  assign IF_Next_PC       = IF_Predict_Taken ? table_q[if_idx].target
                                             : IF_PC + ADDR_W'(4);

  // ---------------- Update ----------------
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CNT_W-1:0] upd_cnt_next;

  assign upd_idx = Update_PC[IDX_W+1:2];
  assign upd_tag = Update_PC[ADDR_W-1:IDX_W+2];
  assign upd_hit = table_q[upd_idx].valid && (table_q[upd_idx].tag == upd_tag);

  btb_sat_counter #(
    .CNT_W (CNT_W)
  ) u_sat_counter (
    .cnt_i (table_q[upd_idx].cnt),
    .inc_i (Update_Taken),
    .cnt_o (upd_cnt_next)
  );

  always_comb begin
    table_d = table_q;
    if (Flush_All) begin
      // Flush wins over a same-cycle update; counters and targets survive.
      for (int i = 0; i < ENTRIES; i++) begin
        table_d[i].valid = 1'b0;
      end
    end else if (Update_Valid) begin
      if (upd_hit) begin
        table_d[upd_idx].cnt = upd_cnt_next;
        if (Update_Taken) table_d[upd_idx].target = Update_Target;
      end else if (Update_Taken) begin
        // Allocate or replace the aliasing entry, starting weakly taken.
        table_d[upd_idx] = '{
          valid:  1'b1,
          tag:    upd_tag,
          target: Update_Target,
          cnt:    CNT_WEAK_T
        };
      end
    end
  end

  // Statistics count every presented update, even one discarded by a flush.
  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (Update_Valid) begin
      stat_upd_d = stat_upd_q + STAT_W'(1);
      if (Update_Taken != Update_Predicted) stat_mis_d = stat_mis_q + STAT_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_ff @(posedge CLK) begin
        if (RESET) table_q[gi] <= RESET_ENTRY;
        else       table_q[gi] <= table_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stat_upd_q <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign Stat_Updates     = stat_upd_q;
  assign Stat_Mispredicts = stat_mis_q;

endmodule

// File: tb/tb_branch_predict_btb.sv
module tb_branch_predict_btb;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] IF_PC;
  logic        IF_Hit;
  logic        IF_Predict_Taken;
  logic [31:0] IF_Next_PC;
  logic        Update_Valid;
  logic [31:0] Update_PC;
  logic        Update_Taken;
  logic        Update_Predicted;
  logic [31:0] Update_Target;
  logic        Flush_All;
  logic [15:0] Stat_Updates;
  logic [15:0] Stat_Mispredicts;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_upd = 0;
  int exp_mis = 0;

  typedef struct {
    logic [31:0] pc;
    logic        hit;
    logic        pt;
    logic [31:0] npc;
  } exp_t;

  exp_t sb_q[$];

  branch_predict_btb #(
    .ENTRIES (16),
    .ADDR_W  (32),
    .CNT_W   (2),
    .STAT_W  (16)
  ) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .IF_PC            (IF_PC),
    .IF_Hit           (IF_Hit),
    .IF_Predict_Taken (IF_Predict_Taken),
    .IF_Next_PC       (IF_Next_PC),
    .Update_Valid     (Update_Valid),
    .Update_PC        (Update_PC),
    .Update_Taken     (Update_Taken),
    .Update_Predicted (Update_Predicted),
    .Update_Target    (Update_Target),
    .Flush_All        (Flush_All),
    .Stat_Updates     (Stat_Updates),
    .Stat_Mispredicts (Stat_Mispredicts)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  // Push the expected lookup result, then compare once the outputs settle.
  task automatic lookup(input logic [31:0] pc, input logic hit, input logic pt, input logic [31:0] npc);
    exp_t e;
    IF_PC = pc;
    sb_q.push_back('{pc: pc, hit: hit, pt: pt, npc: npc});
    #1;
    e = sb_q.pop_front();
    check_val($sformatf("hit@%h", e.pc), {31'd0, IF_Hit}, {31'd0, e.hit});
    check_val($sformatf("pt@%h", e.pc), {31'd0, IF_Predict_Taken}, {31'd0, e.pt});
    check_val($sformatf("npc@%h", e.pc), IF_Next_PC, e.npc);
  endtask

  task automatic check_stats(input string tag);
    check_val({tag, "_upd"}, {16'd0, Stat_Updates}, exp_upd & 32'hFFFF);
    check_val({tag, "_mis"}, {16'd0, Stat_Mispredicts}, exp_mis & 32'hFFFF);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic present_update(input logic [31:0] pc, input logic taken, input logic pred,
                                input logic [31:0] tgt, input logic flush);
    Update_Valid     = 1'b1;
    Update_PC        = pc;
    Update_Taken     = taken;
    Update_Predicted = pred;
    Update_Target    = tgt;
    Flush_All        = flush;
    if (!RESET) begin
      exp_upd++;
      if (taken != pred) exp_mis++;
    end
  endtask

  task automatic idle_inputs();
    Update_Valid = 1'b0;
    Flush_All    = 1'b0;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic pred, input logic [31:0] tgt);
    present_update(pc, taken, pred, tgt, 1'b0);
    step();
    idle_inputs();
  endtask

  initial begin
    RESET = 1'b1;
    IF_PC = 32'h0;
    Update_PC = 32'h0;
    Update_Taken = 1'b0;
    Update_Predicted = 1'b0;
    Update_Target = 32'h0;
    idle_inputs();
    step();
    step();
    RESET = 1'b0;

    // Reset state
    lookup(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    check_stats("reset");
    lookup(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // Allocation, weakly taken
    do_update(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0040);
    lookup(32'h0040_0012, 1'b1, 1'b1, 32'h0040_0040);

    // Decrement to 0 with saturation
    do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    // 0 -> 1: still not taken, new target stored
    do_update(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0080);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
    exp_mis = exp_mis; // counter model: mispredict above is tracked by present_update
    // 1 -> 2: taken, target from previous update retained
    do_update(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
    // Upward saturation: 2 -> 3 -> 3, then 3 -> 2 -> 1
    do_update(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
    do_update(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
    do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    lookup(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0080);
    do_update(32'h0040_0010, 1'b0, 1'b0, 32'h0);
    lookup(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);

    // Aliasing on idx 4
    lookup(32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
    do_update(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0100);
    lookup(32'h0040_0050, 1'b1, 1'b1, 32'h0040_0100);
    lookup(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    check_stats("alias");

    // Flush with simultaneous taken update
    present_update(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0300, 1'b1);
    step();
    idle_inputs();
    lookup(32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
    lookup(32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
    check_stats("flush");

    // Same-cycle lookup and update: lookup sees pre-update contents
    present_update(32'h0040_0030, 1'b1, 1'b1, 32'h0040_0200, 1'b0);
    lookup(32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
    step();
    idle_inputs();
    lookup(32'h0040_0030, 1'b1, 1'b1, 32'h0040_0200);

    // Mispredict accounting
    check_val("mis_before", {16'd0, Stat_Mispredicts}, exp_mis);
    do_update(32'h0040_0030, 1'b0, 1'b1, 32'h0);
    check_stats("mispredict");
    lookup(32'h0040_0030, 1'b1, 1'b0, 32'h0040_0034);

    // Reset mid-sequence with an update in the reset cycle
    RESET = 1'b1;
    present_update(32'h0040_0060, 1'b1, 1'b0, 32'h0040_0400, 1'b0);
    step();
    RESET = 1'b0;
    idle_inputs();
    exp_upd = 0;
    exp_mis = 0;
    lookup(32'h0040_0030, 1'b0, 1'b0, 32'h0040_0034);
    lookup(32'h0040_0060, 1'b0, 1'b0, 32'h0040_0064);
    check_stats("midreset");

    // Statistics wrap: 65535 non-taken misses then one more
    Update_Valid     = 1'b1;
    Update_PC        = 32'h0040_0070;
    Update_Taken     = 1'b0;
    Update_Predicted = 1'b0;
    Update_Target    = 32'h0;
    repeat (65535) @(posedge CLK);
    #1;
    exp_upd = 65535;
    check_stats("upd_ffff");
    step();
    idle_inputs();
    exp_upd = exp_upd + 1;
    check_stats("upd_wrap");
    lookup(32'h0040_0070, 1'b0, 1'b0, 32'h0040_0074);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
